// File: rtl/result_select_arb.sv
// Registered N-source result select with fixed-priority or round-robin arbitration.
// A single output register uses valid/ready, and the block can move one transfer per cycle.
module result_select_arb #(
  parameter int WIDTH = 4,
  parameter int NSRC  = 2,
  parameter int MODE  = 0,
  localparam int SRCW = (NSRC > 2) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC-1:0]       src_valid,
  input  logic [NSRC*WIDTH-1:0] src_data,
  output logic [NSRC-1:0]       src_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SRCW-1:0]       out_src,
  input  logic                  out_ready
);

  logic [WIDTH-1:0] src_word [NSRC];
  logic [SRCW-1:0]  rr_ptr;
  logic [SRCW-1:0]  gnt_idx;
  logic [NSRC-1:0]  grant;
  logic             accept;
  logic             xfer;

  for (genvar i = 0; i < NSRC; i++) begin : g_unpack
    assign src_word[i] = src_data[i*WIDTH +: WIDTH];
  end

  // Search positions run from rr_ptr upward in round-robin mode and from 0 in fixed mode.
  // The first valid source found in that order is granted.
  always_comb begin
    int              pos;
    logic [SRCW-1:0] idx;
    logic            found;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    idx     = '0;
    for (int k = 0; k < NSRC; k++) begin
      pos = (MODE == 1) ? (int'(rr_ptr) + k) % NSRC : k;
      idx = SRCW'(pos);
      if (!found && src_valid[idx]) begin
        found        = 1'b1;
        grant[idx]   = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

  assign accept    = ~out_valid | out_ready;
  // Gating with rst_n keeps every source from handshaking while reset is held.
  assign src_ready = (rst_n && accept) ? grant : '0;
  assign xfer      = |src_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= src_word[gnt_idx];
      out_src   <= gnt_idx;
      rr_ptr    <= (gnt_idx == SRCW'(NSRC - 1)) ? '0 : gnt_idx + SRCW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_select_arb.sv
// Bench for result_select_arb: a fixed-priority instance checked from a vector table, and a
// round-robin instance checked against a reference model that feeds an expected-output queue.
module tb_result_select_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Fixed priority instance: WIDTH=4, NSRC=2, MODE=0
  logic [1:0] fp_valid, fp_ready;
  logic [7:0] fp_data;
  logic       fp_ov, fp_os, fp_ordy;
  logic [3:0] fp_od;

  // Round-robin instance: WIDTH=4, NSRC=3, MODE=1
  logic [2:0]  rr_valid, rr_ready;
  logic [11:0] rr_data;
  logic        rr_ov, rr_ordy;
  logic [1:0]  rr_os;
  logic [3:0]  rr_od;

  result_select_arb #(.WIDTH(4), .NSRC(2), .MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .src_valid(fp_valid), .src_data(fp_data),
    .src_ready(fp_ready), .out_valid(fp_ov), .out_data(fp_od), .out_src(fp_os),
    .out_ready(fp_ordy));

  result_select_arb #(.WIDTH(4), .NSRC(3), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .src_valid(rr_valid), .src_data(rr_data),
    .src_ready(rr_ready), .out_valid(rr_ov), .out_data(rr_od), .out_src(rr_os),
    .out_ready(rr_ordy));

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [1:0] v;
    logic [3:0] d0;
    logic [3:0] d1;
    logic       ordy;
    logic [1:0] sr;
    logic       ov;
    logic [3:0] od;
    logic       os;
  } vec_t;

  vec_t tbl [16];

  // Reference model for the round-robin instance
  int         m_ptr = 0;
  bit         m_ov  = 1'b0;
  logic [2:0] last_sr = '0;
  logic [5:0] sb [$];

  task automatic rr_step();
    logic [5:0] item;
    logic [2:0] exp_sr;
    int         g;
    int         idx;
    bit         acc;
    @(negedge clk);
    chk("rr out_valid", 32'(rr_ov), 32'(m_ov));
    if (rr_ov && rr_ordy) begin
      if (sb.size() == 0) begin
        chk("rr output with nothing pending", 32'(rr_ov), 32'd0);
      end else begin
        item = sb.pop_front();
        chk("rr out_data", 32'(rr_od), 32'(item[5:2]));
        chk("rr out_src", 32'(rr_os), 32'(item[1:0]));
      end
    end
    acc = !m_ov || rr_ordy;
    g   = -1;
    if (acc) begin
      for (int k = 0; k < 3; k++) begin
        idx = (m_ptr + k) % 3;
        if (g < 0 && rr_valid[idx]) g = idx;
      end
    end
    exp_sr = (g >= 0) ? 3'(1 << g) : 3'b000;
    chk("rr src_ready", 32'(rr_ready), 32'(exp_sr));
    last_sr = exp_sr;
    if (g >= 0) begin
      sb.push_back({rr_data[g*4 +: 4], 2'(g)});
      m_ptr = (g + 1) % 3;
      m_ov  = 1'b1;
    end else if (rr_ordy) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{2'b11, 4'hA, 4'h5, 1'b1, 2'b01, 1'b1, 4'hA, 1'b0};
    tbl[1]  = '{2'b11, 4'hA, 4'h5, 1'b1, 2'b01, 1'b1, 4'hA, 1'b0};
    tbl[2]  = '{2'b10, 4'hA, 4'h5, 1'b1, 2'b10, 1'b1, 4'h5, 1'b1};
    tbl[3]  = '{2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 1'b0, 4'h5, 1'b1};
    tbl[4]  = '{2'b00, 4'h0, 4'h0, 1'b0, 2'b00, 1'b0, 4'h5, 1'b1};
    tbl[5]  = '{2'b10, 4'h0, 4'h7, 1'b0, 2'b10, 1'b1, 4'h7, 1'b1};
    tbl[6]  = '{2'b10, 4'h0, 4'h9, 1'b0, 2'b00, 1'b1, 4'h7, 1'b1};
    tbl[7]  = '{2'b10, 4'h0, 4'h9, 1'b0, 2'b00, 1'b1, 4'h7, 1'b1};
    tbl[8]  = '{2'b10, 4'h0, 4'h9, 1'b0, 2'b00, 1'b1, 4'h7, 1'b1};
    tbl[9]  = '{2'b10, 4'h0, 4'h9, 1'b1, 2'b10, 1'b1, 4'h9, 1'b1};
    tbl[10] = '{2'b10, 4'h0, 4'h3, 1'b1, 2'b10, 1'b1, 4'h3, 1'b1};
    tbl[11] = '{2'b01, 4'hC, 4'h0, 1'b0, 2'b00, 1'b1, 4'h3, 1'b1};
    tbl[12] = '{2'b01, 4'hC, 4'h0, 1'b1, 2'b01, 1'b1, 4'hC, 1'b0};
    tbl[13] = '{2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 1'b0, 4'hC, 1'b0};
    tbl[14] = '{2'b00, 4'h0, 4'h0, 1'b1, 2'b00, 1'b0, 4'hC, 1'b0};
    tbl[15] = '{2'b11, 4'h2, 4'h4, 1'b0, 2'b01, 1'b1, 4'h2, 1'b0};

    fp_valid = '0; fp_data = '0; fp_ordy = 1'b0;
    rr_valid = '0; rr_data = '0; rr_ordy = 1'b0;

    // Reset state, and no handshake while reset is held
    repeat (2) @(posedge clk);
    #1;
    fp_valid = 2'b11;
    rr_valid = 3'b111;
    #1;
    chk("reset fp src_ready", 32'(fp_ready), 32'd0);
    chk("reset rr src_ready", 32'(rr_ready), 32'd0);
    chk("reset fp out_valid", 32'(fp_ov), 32'd0);
    chk("reset fp out_data", 32'(fp_od), 32'd0);
    chk("reset fp out_src", 32'(fp_os), 32'd0);
    chk("reset rr out_valid", 32'(rr_ov), 32'd0);
    fp_valid = '0;
    rr_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fixed priority: vector table
    for (int i = 0; i < 16; i++) begin
      fp_valid = tbl[i].v;
      fp_data  = {tbl[i].d1, tbl[i].d0};
      fp_ordy  = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("fp v%0d src_ready", i), 32'(fp_ready), 32'(tbl[i].sr));
      @(posedge clk);
      #1;
      chk($sformatf("fp v%0d out_valid", i), 32'(fp_ov), 32'(tbl[i].ov));
      chk($sformatf("fp v%0d out_data", i), 32'(fp_od), 32'(tbl[i].od));
      chk($sformatf("fp v%0d out_src", i), 32'(fp_os), 32'(tbl[i].os));
    end
    fp_valid = '0;
    fp_ordy  = 1'b1;

    // Round-robin fairness: all sources valid with data 1,2,3
    rr_valid = 3'b111;
    rr_data  = {4'h3, 4'h2, 4'h1};
    rr_ordy  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rr_step();
      chk($sformatf("rr fair %0d out_src", k), 32'(rr_os), 32'(k % 3));
      chk($sformatf("rr fair %0d out_data", k), 32'(rr_od), 32'(k % 3 + 1));
    end

    // Backpressure: hold 7 for three stalled cycles; pointer must stay at 1
    rr_valid = 3'b001;
    rr_data  = {4'h0, 4'h0, 4'h7};
    rr_step();
    rr_valid = 3'b110;
    rr_data  = {4'h5, 4'h9, 4'h0};
    rr_ordy  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rr_step();
      chk($sformatf("rr stall %0d out_data", k), 32'(rr_od), 32'h7);
    end
    rr_ordy = 1'b1;
    rr_step();
    chk("rr after stall out_src", 32'(rr_os), 32'd1);
    chk("rr after stall out_data", 32'(rr_od), 32'h9);
    rr_valid = 3'b100;
    rr_step();
    chk("rr next out_src", 32'(rr_os), 32'd2);
    rr_valid = 3'b000;
    rr_step();

    // Random traffic; sources hold their data until they are granted
    for (int c = 0; c < 80; c++) begin
      rr_step();
      for (int i = 0; i < 3; i++) begin
        if (!(rr_valid[i] && !last_sr[i])) begin
          rr_valid[i] = 1'($urandom_range(0, 1));
          rr_data[i*4 +: 4] = 4'($urandom_range(0, 15));
        end
      end
      rr_ordy = ($urandom_range(0, 3) != 0);
    end
    rr_valid = 3'b000;
    rr_ordy  = 1'b1;
    repeat (2) rr_step();
    chk("rr scoreboard drained", 32'(sb.size()), 32'd0);

    // Reset mid-operation: held output is discarded, pointer returns to 0
    rr_valid = 3'b001;
    rr_data  = {4'h0, 4'h0, 4'h4};
    fp_valid = 2'b01;
    fp_data  = {4'h0, 4'hC};
    fp_ordy  = 1'b1;
    rr_step();
    chk("pre-reset fp out_valid", 32'(fp_ov), 32'd1);
    chk("pre-reset fp out_data", 32'(fp_od), 32'hC);
    fp_ordy  = 1'b0;
    fp_valid = 2'b11;
    rr_valid = 3'b111;
    rr_ordy  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset fp out_valid", 32'(fp_ov), 32'd0);
    chk("midreset fp out_data", 32'(fp_od), 32'd0);
    chk("midreset fp out_src", 32'(fp_os), 32'd0);
    chk("midreset fp src_ready", 32'(fp_ready), 32'd0);
    chk("midreset rr out_valid", 32'(rr_ov), 32'd0);
    chk("midreset rr src_ready", 32'(rr_ready), 32'd0);
    m_ov  = 1'b0;
    m_ptr = 0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rr_data  = {4'h3, 4'h2, 4'h1};
    rr_ordy  = 1'b1;
    rr_step();
    chk("post-reset rr out_src", 32'(rr_os), 32'd0);
    chk("post-reset rr out_data", 32'(rr_od), 32'h1);
    rr_step();
    chk("post-reset rr second out_src", 32'(rr_os), 32'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/result_select_arb.md
# result_select_arb

Registered, parametrised successor to the processor's 2-to-1 result select. It picks one of `NSRC` result sources (load unit, ALU, and later sources) and places it in a single-entry output register. Each source uses a valid/ready handshake toward the block, and the output uses valid/ready toward the register-file write port. The block arbitrates between sources by fixed priority or round-robin, holds its output under backpressure, and sustains one transfer per cycle.

## Interface
Parameters:
- `WIDTH`, 4: data width of every source and of the output.
- `NSRC`, 2: number of sources; legal range 2..8. Index 0 is the load path, index 1 is the ALU.
- `MODE`, 0: arbitration mode. 0 = fixed priority, lowest index wins. 1 = round-robin.
- `SRCW`, derived: max(1, clog2(`NSRC`)). Not for override.

Ports:
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `src_valid`, in, `NSRC`: bit i set means source i presents data.
- `src_data`, in, `NSRC*WIDTH`: source i occupies bits [i*WIDTH +: WIDTH].
- `src_ready`, out, `NSRC`: one-hot or zero. Bit i set means source i transfers this cycle.
- `out_valid`, out, 1: output register holds valid data.
- `out_data`, out, `WIDTH`: registered selected data.
- `out_src`, out, `SRCW`: index of the source that produced `out_data`.
- `out_ready`, in, 1: consumer accepts the output this cycle.

## Operation
- `accept` = !`out_valid` | `out_ready`. It means the output register is free or is draining this cycle.
- Grant in `MODE` 0: the lowest i with `src_valid`[i] set.
- Grant in `MODE` 1: the first i with `src_valid`[i] set, searching from `rr_ptr` upward and wrapping from `NSRC`-1 to 0.
- `src_ready`[i] = `accept` & grant[i]. It is combinational from `src_valid` and `out_ready`. There is no combinational path to any `out_*` signal.
- Transfer: when `src_ready`[i] is set, `out_data` <= source i data, `out_src` <= i, and `out_valid` <= 1.
- Drain with no new source (`out_ready` set, no `src_valid` bit set): `out_valid` <= 0. `out_data` and `out_src` keep their last values.
- Stall (`out_valid` set, `out_ready` clear): `out_data`, `out_src` and `out_valid` stay stable, all `src_ready` bits are 0, and `rr_ptr` is unchanged.
- `rr_ptr` (width `SRCW`) updates only on a transfer, to the granted index + 1, wrapping to 0 after `NSRC`-1. In `MODE` 0, `rr_ptr` has no effect.
- A source whose valid is not granted keeps waiting. The block never drops or duplicates its data. Sources hold their data while valid is set and ready is clear.

## Timing
- Reset values (asynchronous, immediate on `rst_n` falling):
  - `out_valid` = 0
  - `out_data` = 0
  - `out_src` = 0
  - `rr_ptr` = 0
  - `src_ready` = 0 while `rst_n` is low
- Reset release: operation is normal from the first rising edge with `rst_n` high.
- Reset mid-operation: a held output is discarded and never presented. A transfer in the same cycle is lost on the source side, and the source must re-present.
- Latency: source transfer to `out_valid` is 1 cycle.
- Throughput: 1 transfer per cycle while `out_ready` stays high. Drain and fill in the same cycle cause no bubble.
- Fairness in `MODE` 1: with all sources continuously valid and `out_ready` high, each source is granted once every `NSRC` cycles.
- Starvation: in `MODE` 0, the lowest-priority source can starve; this is expected. In `MODE` 1, every waiting source is granted within `NSRC` transfers.

## Test plan
- Reset: assert `rst_n` low while `out_valid`=1 and `out_data`=4'hC, between clock edges. `out_valid`=0, `out_data`=0 and `out_src`=0 immediately. After release, the first transfer's `out_src` follows `rr_ptr`=0.
- Fixed priority (`WIDTH`=4, `NSRC`=2, `MODE`=0): src0=4'hA and src1=4'h5 both valid, `out_ready`=1. Next cycle: `out_data`=4'hA, `out_src`=0. src1 gets `src_ready` only after `src_valid`[0] drops, then `out_data`=4'h5.
- Round-robin (`NSRC`=3, `MODE`=1): all sources continuously valid with data 1, 2, 3, `out_ready`=1. `out_src` sequence is 0,1,2,0,1,2 on consecutive cycles; `out_data` is 1,2,3,1,2,3.
- Backpressure: `out_valid`=1, `out_data`=4'h7, `out_ready`=0 for 3 cycles with src1 valid. Output stays 4'h7, all `src_ready` bits are 0, `rr_ptr` is unchanged. On `out_ready`=1, src1 transfers in that cycle and its data appears the next cycle.
- Drain and fill (`MODE`=0): `out_valid`=1, `out_ready`=1, src1 valid with data 4'h3. Next cycle: `out_valid`=1, `out_data`=4'h3, `out_src`=1, with no idle cycle between.
- Empty: no `src_valid` bits set, `out_valid`=1, `out_ready`=1. `out_valid`=0 next cycle and `out_data` is unchanged. `src_ready` stays 0 until a source asserts valid.
